// File: rtl/time_set_entry_pkg.sv
// Shared definitions for the keypad time-setting data path.
package time_set_entry_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_CHECK = 2'd2,
        S_LOAD  = 2'd3
    } state_t;

    localparam int DIGIT_W      = 4;
    localparam int BIN_W        = 7;

    localparam int HOUR_MAX_DEF = 23;
    localparam int MIN_MAX_DEF  = 59;
    localparam int SEC_MAX_DEF  = 59;

    localparam int HOUR_W       = 5;
    localparam int MIN_W        = 6;
    localparam int SEC_W        = 6;

endpackage

// File: rtl/time_set_entry_bcd2_field.sv
// Two-digit BCD entry buffer with binary conversion and upper-bound compare.
module bcd2_field
    import time_set_entry_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift,
    input  logic [DIGIT_W-1:0] digit,
    output logic [BIN_W-1:0]   bin,
    output logic               in_range
);

    localparam logic [BIN_W-1:0] MAX_V = BIN_W'(MAX);

    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;

    // Shift a new digit in; a simultaneous clear drops the old ones digit instead of moving it up.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tens <= '0;
            ones <= '0;
        end else if (shift) begin
            tens <= clear ? '0 : ones;
            ones <= digit;
        end else if (clear) begin
            tens <= '0;
            ones <= '0;
        end
    end

    assign bin      = {3'b000, tens} * 7'd10 + {3'b000, ones};
    assign in_range = (bin <= MAX_V);

endmodule

// File: rtl/time_set_entry.sv
// Keypad time entry: captures BCD digits per field, range-checks on commit and
// presents the validated time to the timekeeper over a valid/ready handshake.
module time_set_entry
    import time_set_entry_pkg::*;
#(
    parameter int HOUR_MAX = HOUR_MAX_DEF,
    parameter int MIN_MAX  = MIN_MAX_DEF,
    parameter int SEC_MAX  = SEC_MAX_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               hour_en,
    input  logic               min_en,
    input  logic               sec_en,
    input  logic               completeSetting,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               load_ready,
    output logic               load_valid,
    output logic [HOUR_W-1:0]  set_hour,
    output logic [MIN_W-1:0]   set_min,
    output logic [SEC_W-1:0]   set_sec,
    output logic               field_error,
    output logic               busy
);

    state_t state;

    logic hour_prev, min_prev, sec_prev, commit_prev;
    logic hour_rise, min_rise, sec_rise, commit_rise;
    logic one_en, key_ok;
    logic [BIN_W-1:0] hour_bin, min_bin, sec_bin;
    logic hour_ok, min_ok, sec_ok;
    logic unused_hi;

    assign hour_rise   = hour_en & ~hour_prev;
    assign min_rise    = min_en & ~min_prev;
    assign sec_rise    = sec_en & ~sec_prev;
    assign commit_rise = completeSetting & ~commit_prev;

    // A key is only routed when exactly one field is selected and we are not mid-commit.
    assign one_en = ({1'b0, hour_en} + {1'b0, min_en} + {1'b0, sec_en}) == 2'd1;
    assign key_ok = key_valid && (key_digit <= 4'd9) && one_en &&
                    (state == S_IDLE || state == S_ENTRY);

    assign busy = (state != S_IDLE);

    // Upper conversion bits never reach set_* (range check already bounds them).
    assign unused_hi = ^{hour_bin[BIN_W-1:HOUR_W], min_bin[BIN_W-1:MIN_W], sec_bin[BIN_W-1:SEC_W]};

    bcd2_field #(.MAX(HOUR_MAX)) u_hour (
        .clock    (clock),
        .reset    (reset),
        .clear    (hour_rise),
        .shift    (key_ok & hour_en),
        .digit    (key_digit),
        .bin      (hour_bin),
        .in_range (hour_ok)
    );

    bcd2_field #(.MAX(MIN_MAX)) u_min (
        .clock    (clock),
        .reset    (reset),
        .clear    (min_rise),
        .shift    (key_ok & min_en),
        .digit    (key_digit),
        .bin      (min_bin),
        .in_range (min_ok)
    );

    bcd2_field #(.MAX(SEC_MAX)) u_sec (
        .clock    (clock),
        .reset    (reset),
        .clear    (sec_rise),
        .shift    (key_ok & sec_en),
        .digit    (key_digit),
        .bin      (sec_bin),
        .in_range (sec_ok)
    );

    // Previous-cycle copies of the level inputs for rising-edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hour_prev   <= 1'b0;
            min_prev    <= 1'b0;
            sec_prev    <= 1'b0;
            commit_prev <= 1'b0;
        end else begin
            hour_prev   <= hour_en;
            min_prev    <= min_en;
            sec_prev    <= sec_en;
            commit_prev <= completeSetting;
        end
    end

    // Commit FSM with registered handshake, error pulse and latched output time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            load_valid  <= 1'b0;
            field_error <= 1'b0;
            set_hour    <= '0;
            set_min     <= '0;
            set_sec     <= '0;
        end else begin
            field_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (commit_rise)
                        state <= S_CHECK;
                    else if (hour_en || min_en || sec_en)
                        state <= S_ENTRY;
                end
                S_ENTRY: begin
                    if (commit_rise)
                        state <= S_CHECK;
                end
                S_CHECK: begin
                    if (hour_ok && min_ok && sec_ok) begin
                        set_hour   <= hour_bin[HOUR_W-1:0];
                        set_min    <= min_bin[MIN_W-1:0];
                        set_sec    <= sec_bin[SEC_W-1:0];
                        load_valid <= 1'b1;
                        state      <= S_LOAD;
                    end else begin
                        field_error <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (load_ready) begin
                        load_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_entry.sv
// Scoreboard bench: stimulus queues expected commits, a negedge monitor checks them.
module tb_time_set_entry;

    logic       clock = 1'b0;
    logic       reset;
    logic       hour_en, min_en, sec_en, completeSetting;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       load_ready;
    logic       load_valid;
    logic [4:0] set_hour;
    logic [5:0] set_min, set_sec;
    logic       field_error, busy;

    time_set_entry dut (
        .clock           (clock),
        .reset           (reset),
        .hour_en         (hour_en),
        .min_en          (min_en),
        .sec_en          (sec_en),
        .completeSetting (completeSetting),
        .key_valid       (key_valid),
        .key_digit       (key_digit),
        .load_ready      (load_ready),
        .load_valid      (load_valid),
        .set_hour        (set_hour),
        .set_min         (set_min),
        .set_sec         (set_sec),
        .field_error     (field_error),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit err;
        int h;
        int m;
        int s;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation on every accepted load or error pulse.
    bit   expect_idle = 0;
    bit   prev_stall  = 0;
    bit   prev_err    = 0;
    int   ph, pm, ps;
    always @(negedge clock) begin
        if (reset) begin
            expect_idle = 0;
            prev_stall  = 0;
            prev_err    = 0;
        end else begin
            if (expect_idle) chk("one_cycle_valid", int'(load_valid), 0);
            expect_idle = 0;
            if (prev_stall && load_valid) begin
                chk("stall_hour", int'(set_hour), ph);
                chk("stall_min",  int'(set_min),  pm);
                chk("stall_sec",  int'(set_sec),  ps);
            end
            if (prev_err && field_error) chk("err_pulse_width", 1, 0);
            if (field_error || (load_valid && load_ready)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("kind_err",  int'(field_error), int'(e.err));
                    chk("kind_load", int'(load_valid), int'(!e.err));
                    chk("set_hour",  int'(set_hour), e.h);
                    chk("set_min",   int'(set_min),  e.m);
                    chk("set_sec",   int'(set_sec),  e.s);
                end
                if (load_valid && load_ready) expect_idle = 1;
            end
            prev_stall = load_valid && !load_ready;
            prev_err   = field_error;
            ph = int'(set_hour);
            pm = int'(set_min);
            ps = int'(set_sec);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic key(input int d);
        key_valid = 1'b1;
        key_digit = 4'(d);
        tick();
        key_valid = 1'b0;
    endtask

    task automatic push(input bit err, input int h, input int m, input int s);
        exp_t e;
        e.err = err; e.h = h; e.m = m; e.s = s;
        sb.push_back(e);
    endtask

    task automatic commit();
        completeSetting = 1'b1;
        tick();
        completeSetting = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk(name, sb.size(), 0);
        repeat (2) tick();
    endtask

    // Select exactly one field (0 hour, 1 min, 2 sec, 3 none) then enter two digits.
    task automatic sel(input int f);
        hour_en = (f == 0);
        min_en  = (f == 1);
        sec_en  = (f == 2);
    endtask

    task automatic enter(input int h, input int m, input int s);
        sel(0); tick(); key(h / 10); key(h % 10);
        sel(1); tick(); key(m / 10); key(m % 10);
        sel(2); tick(); key(s / 10); key(s % 10);
        sel(3); tick();
    endtask

    initial begin
        int n;
        reset = 1'b1;
        hour_en = 0; min_en = 0; sec_en = 0; completeSetting = 0;
        key_valid = 0; key_digit = 0; load_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", int'(load_valid), 0);
        chk("rst_hour",  int'(set_hour), 0);
        chk("rst_min",   int'(set_min), 0);
        chk("rst_sec",   int'(set_sec), 0);
        chk("rst_err",   int'(field_error), 0);
        chk("rst_busy",  int'(busy), 0);
        reset = 1'b0;
        tick();

        // 1: basic entry with latency check
        enter(12, 34, 56);
        push(0, 12, 34, 56);
        completeSetting = 1'b1;
        tick();
        chk("lat_check_busy",  int'(busy), 1);
        chk("lat_check_valid", int'(load_valid), 0);
        tick();
        chk("lat_load_valid", int'(load_valid), 1);
        completeSetting = 1'b0;
        drain("t1_drain");

        // 2: hour 24 rejected, outputs keep 12:34:56; then boundary 23:59:59 accepted
        enter(24, 0, 0);
        push(1, 12, 34, 56);
        commit();
        drain("t2_drain");
        chk("t2_busy_after_err", int'(busy), 0);
        enter(23, 59, 59);
        push(0, 23, 59, 59);
        commit();
        drain("t2b_drain");

        // 3: stalled handshake
        load_ready = 1'b0;
        enter(7, 8, 9);
        push(0, 7, 8, 9);
        commit();
        tick();
        repeat (5) tick();
        chk("t3_held_valid", int'(load_valid), 1);
        load_ready = 1'b1;
        drain("t3_drain");

        // 4: illegal digit, two enables, three-digit shift
        sel(0); tick(); key(1); key(2); key(11);
        min_en = 1'b1; tick(); key(7);
        hour_en = 1'b0; tick(); key(1); key(2); key(3);
        sel(2); tick(); key(5);
        sel(3); tick();
        push(0, 12, 23, 5);
        commit();
        drain("t4_drain");

        // 5: key on enable rise wins over clear; re-entry clears hour
        min_en = 1'b1; key_valid = 1'b1; key_digit = 4'd4; tick(); key_valid = 1'b0;
        sel(0); tick(); sel(3); tick();
        push(0, 0, 4, 5);
        commit();
        drain("t5_drain");

        // 6a: second commit rise during LOAD ignored
        load_ready = 1'b0;
        push(0, 0, 4, 5);
        commit();
        tick(); tick();
        commit();
        tick();
        load_ready = 1'b1;
        drain("t6a_drain");
        repeat (5) tick();

        // 6b: async reset while in LOAD
        load_ready = 1'b0;
        enter(1, 2, 3);
        commit();
        n = 0;
        while (!load_valid && n < 20) begin tick(); n++; end
        chk("t6_reached_load", int'(load_valid), 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_valid", int'(load_valid), 0);
        chk("t6_rst_hour",  int'(set_hour), 0);
        chk("t6_rst_min",   int'(set_min), 0);
        chk("t6_rst_busy",  int'(busy), 0);
        tick();
        reset = 1'b0;
        load_ready = 1'b1;
        tick();
        // buffers were cleared by reset: commit gives 00:00:00
        push(0, 0, 0, 0);
        commit();
        drain("t6b_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
